// File: rtl/inst_fetch_queue.sv
// Show-ahead instruction queue between fetch and decode: valid/ready on both sides,
// synchronous flush on redirect, and a NOP (all zeros) presented whenever it is empty.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_inst,
  input  logic [ADDR_W-1:0]        in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pc4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_pc;

  // Ready depends on occupancy only, so a full queue refuses a push even when decode pops.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Pointers, occupancy: cleared on reset and flush; flush also swallows same-cycle push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; contents are only visible through out_valid, which reset clears.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wptr] <= in_inst;
      mem_pc[wptr]   <= in_pc;
    end
  end

  assign head_pc = mem_pc[rptr];

  // Data outputs are gated so stale storage never reaches decode.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    out_inst = '0;
    out_pc   = '0;
    out_pc4  = '0;
    if (out_valid) begin
      out_inst = mem_inst[rptr];
      out_pc   = head_pc;
      out_pc4  = head_pc + ADDR_W'(4);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue, checked against a queue-based model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model: entries are {inst, pc}, head at index 0.
  logic [63:0] model_q[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's current contents.
  task automatic check_model(input string where);
    logic [31:0] e_inst, e_pc, e_pc4;
    e_inst = '0;
    e_pc   = '0;
    e_pc4  = '0;
    if (model_q.size() != 0) begin
      e_inst = model_q[0][63:32];
      e_pc   = model_q[0][31:0];
      e_pc4  = e_pc + 32'd4;
    end
    check({where, ".count"},     64'(count),     64'(model_q.size()));
    check({where, ".in_ready"},  64'(in_ready),  64'(model_q.size() != DEPTH));
    check({where, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    check({where, ".out_inst"},  64'(out_inst),  64'(e_inst));
    check({where, ".out_pc"},    64'(out_pc),    64'(e_pc));
    check({where, ".out_pc4"},   64'(out_pc4),   64'(e_pc4));
  endtask

  // One clock: drive at negedge, check pre-edge state, update model at posedge.
  task automatic cycle(input logic v, input logic r, input logic f,
                       input logic [31:0] inst, input logic [31:0] pc);
    logic do_push, do_pop;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_inst   = inst;
    in_pc     = pc;
    #1;
    check_model("cyc");
    do_push = v && (model_q.size() != DEPTH) && !f;
    do_pop  = r && (model_q.size() != 0) && !f;
    @(posedge clk);
    if (f) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({inst, pc});
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    // Power-on reset.
    #1;
    check("reset.count", 64'(count), 64'd0);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);

    // 1: asynchronous reset mid-traffic with three entries.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 32'h1111_0000 + k, 32'h40 + 4 * k);
    check("t1.count_pre", 64'(count), 64'd3);
    #2;
    reset = 1'b0;
    model_q.delete();
    #1;
    check("t1.count", 64'(count), 64'd0);
    check("t1.out_valid", 64'(out_valid), 64'd0);
    check("t1.out_inst", 64'(out_inst), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1.in_ready", 64'(in_ready), 64'd1);

    // 2: fill with decode stalled, then drain in order.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 32'h2008_0001 + k, 32'(4 * k));
    check("t2.count_full", 64'(count), 64'd4);
    check("t2.in_ready_full", 64'(in_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("t2.out_inst", 64'(out_inst), 64'(32'h2008_0001 + k));
      check("t2.out_pc4", 64'(out_pc4), 64'(4 * (k + 1)));
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
    end
    check("t2.count_empty", 64'(count), 64'd0);
    check("t2.out_inst_empty", 64'(out_inst), 64'd0);

    // 3: push+pop at count=2 holds occupancy; at full only the pop happens.
    cycle(1'b1, 1'b0, 1'b0, 32'h3000_0000, 32'h200);
    cycle(1'b1, 1'b0, 1'b0, 32'h3000_0001, 32'h204);
    cycle(1'b1, 1'b1, 1'b0, 32'h3000_0002, 32'h208);
    check("t3.count_2", 64'(count), 64'd2);
    check("t3.head_pc", 64'(out_pc), 64'h204);
    cycle(1'b1, 1'b0, 1'b0, 32'h3000_0003, 32'h20C);
    cycle(1'b1, 1'b0, 1'b0, 32'h3000_0004, 32'h210);
    check("t3.count_4", 64'(count), 64'd4);
    cycle(1'b1, 1'b1, 1'b0, 32'h3000_0005, 32'h214);
    check("t3.count_3", 64'(count), 64'd3);
    check("t3.head_after", 64'(out_pc), 64'h208);
    drain();

    // 4: ten back-to-back push/pop cycles crossing the pointer wrap.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h4000_0000 + k, 32'h100 + 4 * k);
      check("t4.out_pc", 64'(out_pc), 64'(32'h100 + 4 * k));
      check("t4.count", 64'(count), 64'd1);
    end
    drain();

    // 5: flush with push and pop requested at count=3.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 32'h5000_0000 + k, 32'h300 + 4 * k);
    cycle(1'b1, 1'b1, 1'b1, 32'h5000_00FF, 32'h3FC);
    check("t5.count", 64'(count), 64'd0);
    check("t5.out_valid", 64'(out_valid), 64'd0);
    check("t5.out_pc", 64'(out_pc), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'h5000_0100, 32'h400);
    check("t5.new_head", 64'(out_pc), 64'h400);
    check("t5.count_after", 64'(count), 64'd1);
    drain();

    // 6: PC at the top of the address space, then random traffic.
    cycle(1'b1, 1'b0, 1'b0, 32'h6000_0000, 32'hFFFF_FFFC);
    check("t6.out_pc4_wrap", 64'(out_pc4), 64'd0);
    drain();
    for (int n = 0; n < 1000; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), $urandom(), $urandom());
    end
    drain();
    check("final.count", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
